regfile_670_wrseq: RTL and testbench
====================================

Name: regfile_670_wrseq

Overview:
Write-port sequencer placed directly upstream of the 74670-style 4x4 register file. It accepts write requests (address plus data) over a valid/ready handshake and buffers them in a 2-entry queue. Each request becomes a 670-legal write cycle: address/data setup, an active-low write-enable pulse, then a hold. This turns synchronous datapath writes into the asynchronous strobe timing the register file needs.

Parameters:
AW, 2, write address width (4 registers)
DW, 4, data width
SETUP_CYCLES, 1, cycles wa/d are stable before nwe falls (1..15)
PULSE_CYCLES, 2, cycles nwe is held low (1..15)
HOLD_CYCLES, 1, cycles wa/d stay stable after nwe rises (1..15)

Ports:
clk  in  1  system clock; all state changes on rising edge
nreset  in  1  synchronous reset, active low
req_valid  in  1  write request present
req_ready  out  1  sequencer can accept a request this cycle
req_addr  in  AW  register to write
req_data  in  DW  value to write
wa  out  AW  register file write address
d  out  DW  register file write data
d_oe  out  1  data bus drive enable; 0 means d is released (bench models 'z')
nwe  out  1  register file write enable, active low
busy  out  1  queue non-empty or write cycle in progress
wr_done  out  1  one-cycle pulse in the cycle the HOLD phase ends

Behaviour:
- Reset (nreset=0 at a rising edge), with outputs valid from that edge: nwe=1, d_oe=0, wa=0, d=0, busy=0, wr_done=0, req_ready=0 during reset. Queue and counters are cleared. FSM goes to IDLE.
- Reset mid-cycle aborts the write. nwe returns high on that same edge, so it is never left low. The queued entries are discarded.
- Handshake: a transfer occurs on an edge where req_valid=1 and req_ready=1. req_ready = !reset && (queue count < 2). It is registered-free, so it depends only on state.
- Queue: 2-entry FIFO (count 0..2) with wrap-around pointers. A push and a pop in the same cycle leave count unchanged. A push while full cannot happen because ready is low then.
- FSM states and transitions:
  - IDLE: if the queue is non-empty, pop the head into the output regs wa/d, set d_oe=1, load the counter with SETUP_CYCLES-1, and go to SETUP.
  - SETUP: nwe=1. When the counter reaches 0, load PULSE_CYCLES-1 and go to PULSE.
  - PULSE: nwe=0. When the counter reaches 0, load HOLD_CYCLES-1 and go to HOLD.
  - HOLD: nwe=1, wa/d/d_oe held. When the counter reaches 0, assert wr_done for one cycle.
    - If the queue is non-empty, pop the next entry immediately into wa/d and go to SETUP. This is back-to-back: no IDLE cycle, and d_oe stays 1.
    - Otherwise set d_oe=0 and go to IDLE. wa/d retain their last values.
- Phase lengths are exact: nwe is low for exactly PULSE_CYCLES cycles. From the edge where the entry is popped, nwe falls after SETUP_CYCLES cycles.
- Invariant: wa and d never change while nwe=0, nor in the cycle nwe rises.
- nwe, d_oe, wa and d are all registered outputs (glitch-free strobe).
- Latency: the fastest write is an accept at edge N with the queue empty and in IDLE. The pop happens at N+1 and nwe falls at N+1+SETUP_CYCLES.
- busy = (count != 0) || (state != IDLE).
- A request arriving during a write to the same address is simply queued. There is no coalescing, and writes are issued in order.
- The counter is 4 bits wide. Parameter values of 0 are illegal; an elaboration-time check flags them.

Decomposition:
- Shared package regfile_670_pkg holds:
  - the FSM state encoding: IDLE=2'd0, SETUP=2'd1, PULSE=2'd2, HOLD=2'd3
  - the counter width localparam CW=4
  - the default timing constants
- One sub-module is natural: wrseq_fifo2, a 2-entry parameterised (AW+DW) FIFO with push/pop/count/head outputs. The sequencer FSM and counter stay in the top module.

Test Plan:
- Reset: hold nreset=0 for 3 cycles with req_valid=1. Expect nwe=1, d_oe=0, busy=0 and req_ready=0 throughout. Release reset; req_ready=1 on the next cycle.
- Single write: addr=2, data=4'b0111, defaults. Expect nwe low exactly 2 cycles starting 2 cycles after the accept edge, with wa=2 and d=7 stable from pop to d_oe fall. Expect one wr_done pulse, and the attached regfile_670 reads 7 at address 2.
- Back-to-back: push (0,1),(1,3),(2,7),(3,F) with continuous valid. Expect req_ready to drop when count hits 2 and no IDLE cycle between writes. Expect four nwe pulses in order, and the register file holds 1,3,7,F.
- Timing parameters: SETUP=3, PULSE=4, HOLD=2, single write of (3,A). Expect nwe low exactly 4 cycles and falling 3 cycles after the pop. Expect wr_done 2 cycles after nwe rises.
- Reset mid-pulse: start a write of (1,5), drive nreset=0 while nwe=0. Expect nwe=1 and d_oe=0 on that edge and the queue empty. After release, busy=0 and no further nwe pulse.
- Simultaneous push/pop: with count=1 and a write finishing HOLD, push a new request on the same edge. Expect count to stay 1, the next SETUP to start immediately, and no request lost or duplicated.

Source files
------------

// File: rtl/regfile_670_pkg.sv
// Shared definitions for the 74670 write-port sequencer: FSM encoding, phase counter width, default timing.
package regfile_670_pkg;

    localparam int CW          = 4;
    localparam int MAX_PHASE   = (1 << CW) - 1;

    localparam int DEF_AW      = 2;
    localparam int DEF_DW      = 4;
    localparam int DEF_SETUP   = 1;
    localparam int DEF_PULSE   = 2;
    localparam int DEF_HOLD    = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } wr_state_e;

    // A phase of N cycles counts N-1 down to 0.
    function automatic logic [CW-1:0] phase_load(input int cycles);
        return CW'(cycles - 1);
    endfunction

endpackage

// File: rtl/regfile_670_wrseq_if.sv
// Request handshake plus register-file strobe bundle; master is the requester, slave is the sequencer.
interface regfile_670_wrseq_if
    import regfile_670_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) ();

    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_data;
    logic [AW-1:0] wa;
    logic [DW-1:0] d;
    logic          d_oe;
    logic          nwe;
    logic          busy;
    logic          wr_done;

    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready, wa, d, d_oe, nwe, busy, wr_done
    );

    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready, wa, d, d_oe, nwe, busy, wr_done
    );

endinterface

// File: rtl/wrseq_fifo2.sv
// Two-entry FIFO with wrap-around pointers; head_dat is meaningful whenever count != 0.
// Push and pop in one cycle keep count; the caller never pushes when full nor pops when empty.
module wrseq_fifo2 #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [1:0]   count,
    output logic [W-1:0] head_dat
);

    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count    = count_q;
    assign head_dat = mem_q[rd_ptr_q];

endmodule

// File: rtl/regfile_670_wrseq.sv
// Queues register-file writes and replays each as setup / active-low nwe pulse / hold on registered strobes.
// Accept at N pops at N+1, nwe falls at N+1+SETUP_CYCLES; req_ready drops only in reset or with 2 entries queued.
module regfile_670_wrseq
    import regfile_670_pkg::*;
#(
    parameter int AW           = DEF_AW,
    parameter int DW           = DEF_DW,
    parameter int SETUP_CYCLES = DEF_SETUP,
    parameter int PULSE_CYCLES = DEF_PULSE,
    parameter int HOLD_CYCLES  = DEF_HOLD
) (
    input  logic                clk,
    input  logic                nreset,
    regfile_670_wrseq_if.slave  bus
);

    localparam int EW = AW + DW;

    if (SETUP_CYCLES < 1 || SETUP_CYCLES > MAX_PHASE ||
        PULSE_CYCLES < 1 || PULSE_CYCLES > MAX_PHASE ||
        HOLD_CYCLES  < 1 || HOLD_CYCLES  > MAX_PHASE) begin : g_bad_timing
        $error("regfile_670_wrseq: each phase length must be within 1..15 cycles");
    end

    wr_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] wa_q, wa_d;
    logic [DW-1:0] d_q, d_d;
    logic          d_oe_q, d_oe_d;
    logic          nwe_q, nwe_d;
    logic          wr_done_q, wr_done_d;

    logic [1:0]    fifo_count;
    logic [EW-1:0] head_dat;
    logic          push;
    logic          pop;
    logic          queue_empty;
    logic          phase_end;

    assign queue_empty   = (fifo_count == 2'd0);
    assign phase_end     = (cnt_q == '0);
    assign bus.req_ready = nreset && (fifo_count < 2'd2);
    assign push          = bus.req_valid && bus.req_ready;
    // A new entry is taken either from idle or straight out of a finishing hold (back-to-back).
    assign pop           = !queue_empty &&
                           ((state_q == IDLE) || ((state_q == HOLD) && phase_end));

    wrseq_fifo2 #(
        .W (EW)
    ) u_fifo (
        .clk      (clk),
        .nreset   (nreset),
        .push     (push),
        .push_dat ({bus.req_addr, bus.req_data}),
        .pop      (pop),
        .count    (fifo_count),
        .head_dat (head_dat)
    );

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wa_q      <= '0;
            d_q       <= '0;
            d_oe_q    <= 1'b0;
            nwe_q     <= 1'b1;
            wr_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wa_q      <= wa_d;
            d_q       <= d_d;
            d_oe_q    <= d_oe_d;
            nwe_q     <= nwe_d;
            wr_done_q <= wr_done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (!queue_empty) begin
                    state_d = SETUP;
                    cnt_d   = phase_load(SETUP_CYCLES);
                end
            end
            SETUP: begin
                if (phase_end) begin
                    state_d = PULSE;
                    cnt_d   = phase_load(PULSE_CYCLES);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            PULSE: begin
                if (phase_end) begin
                    state_d = HOLD;
                    cnt_d   = phase_load(HOLD_CYCLES);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            HOLD: begin
                if (phase_end) begin
                    if (!queue_empty) begin
                        state_d = SETUP;
                        cnt_d   = phase_load(SETUP_CYCLES);
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Strobes are registered from the next state so nwe is low for exactly the PULSE cycles.
    always_comb begin
        wa_d      = wa_q;
        d_d       = d_q;
        if (pop) begin
            wa_d = head_dat[EW-1:DW];
            d_d  = head_dat[DW-1:0];
        end
        d_oe_d    = (state_d != IDLE);
        nwe_d     = (state_d != PULSE);
        wr_done_d = (state_q == HOLD) && phase_end;
    end

    assign bus.wa      = wa_q;
    assign bus.d       = d_q;
    assign bus.d_oe    = d_oe_q;
    assign bus.nwe     = nwe_q;
    assign bus.wr_done = wr_done_q;
    assign bus.busy    = !queue_empty || (state_q != IDLE);

endmodule

// File: tb/tb_regfile_670_wrseq.sv
// Directed bench: default-timing sequencer plus a slow-timing (3/4/2) instance, each driving a 4x4 register-file model.
module tb_regfile_670_wrseq;

    logic clk = 1'b0;
    logic nreset;

    always #5 clk = ~clk;

    regfile_670_wrseq_if #(.AW(2), .DW(4)) if_a ();
    regfile_670_wrseq_if #(.AW(2), .DW(4)) if_b ();

    regfile_670_wrseq #(
        .AW(2), .DW(4), .SETUP_CYCLES(1), .PULSE_CYCLES(2), .HOLD_CYCLES(1)
    ) u_dut_a (
        .clk    (clk),
        .nreset (nreset),
        .bus    (if_a)
    );

    regfile_670_wrseq #(
        .AW(2), .DW(4), .SETUP_CYCLES(3), .PULSE_CYCLES(4), .HOLD_CYCLES(2)
    ) u_dut_b (
        .clk    (clk),
        .nreset (nreset),
        .bus    (if_b)
    );

    wire [3:0] d_bus_a = if_a.d_oe ? if_a.d : 4'bz;
    wire [3:0] d_bus_b = if_b.d_oe ? if_b.d : 4'bz;

    logic [3:0] mem_a [4] = '{default: 4'h0};
    logic [3:0] mem_b [4] = '{default: 4'h0};
    logic [1:0] fall_wa [$];
    int         stable_viol_a = 0;
    logic       nwe_prev_a = 1'b1;
    logic [1:0] wa_prev_a = 2'd0;
    logic [3:0] d_prev_a = 4'd0;

    int n_checks = 0;
    int n_errors = 0;

    // Register-file model (transparent while nwe is low) and strobe-stability monitor on instance A.
    always @(negedge clk) begin
        if (if_a.nwe === 1'b0) mem_a[if_a.wa] = d_bus_a;
        if (if_b.nwe === 1'b0) mem_b[if_b.wa] = d_bus_b;
        if (nwe_prev_a === 1'b1 && if_a.nwe === 1'b0) fall_wa.push_back(if_a.wa);
        if (if_a.d_oe === 1'b1 && (nwe_prev_a === 1'b0 || if_a.nwe === 1'b0) &&
            (if_a.wa !== wa_prev_a || if_a.d !== d_prev_a)) stable_viol_a++;
        nwe_prev_a = if_a.nwe;
        wa_prev_a  = if_a.wa;
        d_prev_a   = if_a.d;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input int nwe, input int doe, input int wa,
                         input int d, input int done);
        check({tag, ".nwe"},     32'(if_a.nwe),     nwe);
        check({tag, ".d_oe"},    32'(if_a.d_oe),    doe);
        check({tag, ".wa"},      32'(if_a.wa),      wa);
        check({tag, ".d"},       32'(if_a.d),       d);
        check({tag, ".wr_done"}, 32'(if_a.wr_done), done);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [1:0] a, input logic [3:0] dat);
        if_a.req_valid = v;
        if_a.req_addr  = a;
        if_a.req_data  = dat;
    endtask

    logic [5:0] b2b [4] = '{{2'd0, 4'h1}, {2'd1, 4'h3}, {2'd2, 4'h7}, {2'd3, 4'hF}};
    int         exp_falls [9] = '{2, 0, 1, 2, 3, 0, 1, 2, 1};

    initial begin
        int   k;
        int   doe_gaps;
        int   dones;
        int   low_after;
        int   busy_after;
        logic acc;

        // Reset held with requests pending: nothing may be accepted.
        nreset = 1'b0;
        drive_a(1'b1, 2'd3, 4'hF);
        if_b.req_valid = 1'b1;
        if_b.req_addr  = 2'd1;
        if_b.req_data  = 4'h2;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_a($sformatf("rst%0d", i), 1, 0, 0, 0, 0);
            check($sformatf("rst%0d.busy", i),  32'(if_a.busy),      0);
            check($sformatf("rst%0d.ready", i), 32'(if_a.req_ready), 0);
            check($sformatf("rst%0d.b_nwe", i), 32'(if_b.nwe),       1);
            check($sformatf("rst%0d.b_rdy", i), 32'(if_b.req_ready), 0);
        end
        nreset = 1'b1;
        drive_a(1'b0, 2'd0, 4'h0);
        if_b.req_valid = 1'b0;
        tick();
        check("rel.ready_a", 32'(if_a.req_ready), 1);
        check("rel.ready_b", 32'(if_b.req_ready), 1);
        check("rel.busy_a",  32'(if_a.busy),      0);

        // Single write (2,7) with default timing.
        drive_a(1'b1, 2'd2, 4'h7);
        tick();
        drive_a(1'b0, 2'd0, 4'h0);
        chk_a("sw1", 1, 0, 0, 0, 0);
        check("sw1.busy", 32'(if_a.busy), 1);
        tick(); chk_a("sw2", 1, 1, 2, 7, 0);
        tick(); chk_a("sw3", 0, 1, 2, 7, 0);
        tick(); chk_a("sw4", 0, 1, 2, 7, 0);
        tick(); chk_a("sw5", 1, 1, 2, 7, 0);
        tick(); chk_a("sw6", 1, 0, 2, 7, 1);
        check("sw6.busy", 32'(if_a.busy), 0);
        tick(); chk_a("sw7", 1, 0, 2, 7, 0);
        check("sw.mem2", 32'(mem_a[2]), 32'h7);

        // Back-to-back: four requests with valid held, one write every 4 cycles.
        k = 0; doe_gaps = 0; dones = 0;
        drive_a(1'b1, b2b[0][5:4], b2b[0][3:0]);
        for (int i = 1; i <= 18; i++) begin
            acc = if_a.req_valid && if_a.req_ready;
            tick();
            if (acc) k++;
            if (k < 4) drive_a(1'b1, b2b[k][5:4], b2b[k][3:0]);
            else       drive_a(1'b0, 2'd0, 4'h0);
            if (i == 3) check("b2b.ready_full", 32'(if_a.req_ready), 0);
            if (i >= 2 && i <= 17 && if_a.d_oe !== 1'b1) doe_gaps++;
            if (if_a.wr_done === 1'b1) dones++;
        end
        check("b2b.accepted", k,        4);
        check("b2b.doe_gaps", doe_gaps, 0);
        check("b2b.wr_done",  dones,    4);
        check("b2b.busy_end", 32'(if_a.busy), 0);
        check("b2b.mem0", 32'(mem_a[0]), 32'h1);
        check("b2b.mem1", 32'(mem_a[1]), 32'h3);
        check("b2b.mem2", 32'(mem_a[2]), 32'h7);
        check("b2b.mem3", 32'(mem_a[3]), 32'hF);

        // Push on the same edge as the HOLD-end pop with one entry already queued.
        drive_a(1'b1, 2'd0, 4'h5);
        tick(); drive_a(1'b0, 2'd0, 4'h0);
        tick(); drive_a(1'b1, 2'd1, 4'h6);
        tick(); drive_a(1'b0, 2'd0, 4'h0);
        tick();
        tick();
        chk_a("pp5", 1, 1, 0, 5, 0);
        check("pp5.ready", 32'(if_a.req_ready), 1);
        drive_a(1'b1, 2'd2, 4'h9);
        tick(); drive_a(1'b0, 2'd0, 4'h0);
        chk_a("pp6", 1, 1, 1, 6, 1);
        check("pp6.ready", 32'(if_a.req_ready), 1);
        tick(); chk_a("pp7", 0, 1, 1, 6, 0);
        tick(); tick(); tick();
        chk_a("pp10", 1, 1, 2, 9, 1);
        tick(); tick(); tick(); tick();
        chk_a("pp14", 1, 0, 2, 9, 1);
        check("pp14.busy", 32'(if_a.busy), 0);
        check("pp.mem0", 32'(mem_a[0]), 32'h5);
        check("pp.mem1", 32'(mem_a[1]), 32'h6);
        check("pp.mem2", 32'(mem_a[2]), 32'h9);

        // Slow timing instance: SETUP=3, PULSE=4, HOLD=2, write (3,A) accepted at T1.
        if_b.req_valid = 1'b1;
        if_b.req_addr  = 2'd3;
        if_b.req_data  = 4'hA;
        tick();
        if_b.req_valid = 1'b0;
        check("tp1.nwe", 32'(if_b.nwe), 1);
        for (int t = 2; t <= 12; t++) begin
            tick();
            check($sformatf("tp%0d.nwe", t),  32'(if_b.nwe),     (t >= 5 && t <= 8) ? 0 : 1);
            check($sformatf("tp%0d.doe", t),  32'(if_b.d_oe),    (t >= 2 && t <= 10) ? 1 : 0);
            check($sformatf("tp%0d.done", t), 32'(if_b.wr_done), (t == 11) ? 1 : 0);
            if (t <= 10) check($sformatf("tp%0d.wa_d", t), 32'({if_b.wa, if_b.d}), 32'h3A);
        end
        check("tp.mem3", 32'(mem_b[3]), 32'hA);

        // Reset while nwe is low, with a second entry still queued.
        drive_a(1'b1, 2'd1, 4'h5);
        tick(); drive_a(1'b1, 2'd2, 4'h8);
        tick(); drive_a(1'b0, 2'd0, 4'h0);
        tick();
        check("rm3.nwe", 32'(if_a.nwe), 0);
        nreset = 1'b0;
        tick();
        chk_a("rm4", 1, 0, 0, 0, 0);
        check("rm4.busy",  32'(if_a.busy),      0);
        check("rm4.ready", 32'(if_a.req_ready), 0);
        nreset = 1'b1;
        low_after = 0; busy_after = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (if_a.nwe !== 1'b1) low_after++;
            if (if_a.busy !== 1'b0) busy_after++;
        end
        check("rm.nwe_after",  low_after,  0);
        check("rm.busy_after", busy_after, 0);
        check("rm.ready",      32'(if_a.req_ready), 1);

        // Whole-run strobe order and stability on instance A.
        check("falls.count", fall_wa.size(), 9);
        for (int i = 0; i < fall_wa.size() && i < 9; i++) begin
            check($sformatf("falls[%0d].wa", i), 32'(fall_wa[i]), exp_falls[i]);
        end
        check("stable.wa_d", stable_viol_a, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
